// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: PC/IR outputs toward imem and decode, redirect inputs from decode.
// FETCH_PERF_CNT_EN adds the fetch/redirect counter outputs.
interface fetch_if;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_offset_i;
    logic        jump_i;
    logic [25:0] jump_target_i;
    logic        jr_i;
    logic [31:0] jr_addr_i;
    logic [31:0] instr_o;
    logic [31:0] ir_pc_o;
    logic        instr_valid_o;
    logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] redirect_cnt_o;

    modport master (
        output pc_o, instr_o, ir_pc_o, instr_valid_o, halted_o, fetch_cnt_o, redirect_cnt_o,
        input  instr_i, stall_i, branch_taken_i, branch_offset_i, jump_i, jump_target_i,
               jr_i, jr_addr_i
    );
    modport slave (
        input  pc_o, instr_o, ir_pc_o, instr_valid_o, halted_o, fetch_cnt_o, redirect_cnt_o,
        output instr_i, stall_i, branch_taken_i, branch_offset_i, jump_i, jump_target_i,
               jr_i, jr_addr_i
    );
`else
    modport master (
        output pc_o, instr_o, ir_pc_o, instr_valid_o, halted_o,
        input  instr_i, stall_i, branch_taken_i, branch_offset_i, jump_i, jump_target_i,
               jr_i, jr_addr_i
    );
    modport slave (
        input  pc_o, instr_o, ir_pc_o, instr_valid_o, halted_o,
        output instr_i, stall_i, branch_taken_i, branch_offset_i, jump_i, jump_target_i,
               jr_i, jr_addr_i
    );
`endif
endinterface

// File: rtl/fetch_unit.sv
// PC + instruction register feeding decode; resolves jr/jump/branch redirects, halts on bad PC.
// Latency 1 cycle pc_o->instr_o; stall_i freezes PC/IR, each redirect costs one bubble.
// FETCH_PERF_CNT_EN (optional) adds fetch and redirect counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 8
) (
    input logic      clk,
    input logic      reset,
    fetch_if.master  fif
);
    localparam logic [32:0] PC_LIMIT = 33'd4 << IMEM_DEPTH;

    typedef enum logic [1:0] {FILL, RUN, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        valid;
    logic        halted;

    logic [31:0] seq_pc;
    logic [31:0] ir_pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;
    logic        next_bad;
    logic        load_ir;
    logic        take_redirect;

    always_comb begin
        seq_pc      = pc + 32'd4;
        ir_pc_plus4 = ir_pc + 32'd4;
        redirect    = valid && (fif.jr_i || fif.jump_i || fif.branch_taken_i);
        next_pc     = seq_pc;
        if (valid && fif.jr_i)
            next_pc = fif.jr_addr_i;
        else if (valid && fif.jump_i)
            next_pc = {ir_pc_plus4[31:28], fif.jump_target_i, 2'b00};
        else if (valid && fif.branch_taken_i)
            next_pc = ir_pc_plus4 + (fif.branch_offset_i << 2);
        next_bad      = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= PC_LIMIT);
        load_ir       = (state == FILL) ||
                        (state == RUN && !fif.stall_i && !redirect && !next_bad);
        take_redirect = (state == RUN) && !fif.stall_i && redirect && !next_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FILL;
            pc     <= RESET_PC;
            ir     <= 32'h0;
            ir_pc  <= RESET_PC;
            valid  <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    ir    <= fif.instr_i;
                    ir_pc <= pc;
                    valid <= 1'b1;
                    pc    <= seq_pc;
                    state <= RUN;
                end
                RUN: begin
                    if (!fif.stall_i) begin
                        if (next_bad) begin
                            // PC stays at the last good address so the fault can be inspected
                            valid  <= 1'b0;
                            halted <= 1'b1;
                            state  <= HALT;
                        end else if (redirect) begin
                            pc    <= next_pc;
                            valid <= 1'b0;
                        end else begin
                            ir    <= fif.instr_i;
                            ir_pc <= pc;
                            valid <= 1'b1;
                            pc    <= next_pc;
                        end
                    end
                end
                default: begin
                    valid  <= 1'b0;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    assign fif.pc_o          = pc;
    assign fif.instr_o       = ir;
    assign fif.ir_pc_o       = ir_pc;
    assign fif.instr_valid_o = valid;
    assign fif.halted_o      = halted;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt    <= 32'h0;
            redirect_cnt <= 32'h0;
        end else begin
            if (load_ir)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (take_redirect)
                redirect_cnt <= redirect_cnt + 32'd1;
        end
    end

    assign fif.fetch_cnt_o    = fetch_cnt;
    assign fif.redirect_cnt_o = redirect_cnt;
`else
    logic unused_cnt;
    assign unused_cnt = load_ir ^ take_redirect;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized redirects/stalls/resets,
// all checked against a PC-level reference model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_DEPTH = 8;
    localparam longint      LIMIT      = 4 * (2 ** IMEM_DEPTH);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_if fif ();
    fetch_unit #(.RESET_PC(RESET_PC), .IMEM_DEPTH(IMEM_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    logic [31:0] mem [0:255];
    assign fif.instr_i = mem[fif.pc_o[9:2]];

    // reference model state
    logic [31:0] m_pc, m_ir, m_ir_pc, m_fcnt, m_rcnt;
    bit          m_valid, m_halted, m_need_fill;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", fif.pc_o, m_pc);
        chk("instr", fif.instr_o, m_ir);
        chk("ir_pc", fif.ir_pc_o, m_ir_pc);
        chk("valid", fif.instr_valid_o, m_valid);
        chk("halted", fif.halted_o, m_halted);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fif.fetch_cnt_o, m_fcnt);
        chk("redirect_cnt", fif.redirect_cnt_o, m_rcnt);
`endif
    endtask

    // Called at negedge: apply inputs, advance model across one posedge, check at next negedge.
    task automatic step(input bit r, input bit st, input bit br, input logic [31:0] off,
                        input bit j, input logic [25:0] jt, input bit jr, input logic [31:0] ja);
        logic [31:0] word, dest;
        bit          redir;
        reset = r;
        fif.stall_i = st; fif.branch_taken_i = br; fif.branch_offset_i = off;
        fif.jump_i = j; fif.jump_target_i = jt; fif.jr_i = jr; fif.jr_addr_i = ja;
        word = mem[m_pc[9:2]];
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_ir = 0; m_ir_pc = RESET_PC;
            m_valid = 0; m_halted = 0; m_need_fill = 1; m_fcnt = 0; m_rcnt = 0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (m_need_fill) begin
            m_ir = word; m_ir_pc = m_pc; m_valid = 1; m_pc = m_pc + 4;
            m_need_fill = 0; m_fcnt++;
        end else if (!st) begin
            redir = m_valid && (jr || j || br);
            if (m_valid && jr)      dest = ja;
            else if (m_valid && j)  dest = ((m_ir_pc + 4) & 32'hF000_0000) | ({6'b0, jt} * 4);
            else if (m_valid && br) dest = m_ir_pc + 4 + off * 4;
            else                    dest = m_pc + 4;
            if ((dest % 4) != 0 || longint'(dest) >= LIMIT) begin
                m_halted = 1; m_valid = 0;
            end else if (redir) begin
                m_pc = dest; m_valid = 0; m_rcnt++;
            end else begin
                m_ir = word; m_ir_pc = m_pc; m_valid = 1; m_pc = dest; m_fcnt++;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] held_pc;
        int          jumps, guard;
        bit          seen_store;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        reset = 1;
        fif.stall_i = 0; fif.branch_taken_i = 0; fif.branch_offset_i = 0;
        fif.jump_i = 0; fif.jump_target_i = 0; fif.jr_i = 0; fif.jr_addr_i = 0;
        @(negedge clk);

        // sequential start-up
        do_reset();
        chk("rst_pc", fif.pc_o, 32'h0);
        chk("rst_valid", fif.instr_valid_o, 1'b0);
        idle(); chk("seq_pc1", fif.pc_o, 32'h4); chk("seq_irpc1", fif.ir_pc_o, 32'h0);
        idle(); chk("seq_pc2", fif.pc_o, 32'h8); chk("seq_irpc2", fif.ir_pc_o, 32'h4);
        idle(); chk("seq_pc3", fif.pc_o, 32'hC); chk("seq_irpc3", fif.ir_pc_o, 32'h8);
        idle(); chk("seq_irpc4", fif.ir_pc_o, 32'hC);

        // taken branch from ir_pc=12, offset 7
        step(0, 0, 1, 32'd7, 0, 0, 0, 0);
        chk("br_pc", fif.pc_o, 32'h2C);
        chk("br_bubble", fif.instr_valid_o, 1'b0);
        idle();
        chk("br_irpc", fif.ir_pc_o, 32'h2C);
        chk("br_instr", fif.instr_o, mem[11]);

        // stall with a branch held: nothing moves
        held_pc = fif.pc_o;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 32'd5, 0, 0, 0, 0);
            chk("stall_pc", fif.pc_o, held_pc);
        end
        idle();
        chk("post_stall_irpc", fif.ir_pc_o, held_pc);

        // loop: jump at 0x18 back to 0x0C six times, then fall through to 0x1C
        do_reset();
        jumps = 0; guard = 0; seen_store = 0;
        while (!seen_store && guard < 200) begin
            if (fif.instr_valid_o && fif.ir_pc_o == 32'h18 && jumps < 6) begin
                step(0, 0, 0, 0, 1, 26'h3, 0, 0);
                jumps++;
                if (jumps == 1) chk("jump_pc", fif.pc_o, 32'hC);
            end else begin
                idle();
            end
            if (fif.instr_valid_o && fif.ir_pc_o == 32'h1C) seen_store = 1;
            guard++;
        end
        chk("loop_reached_store", seen_store, 1'b1);
        chk("loop_jumps", jumps, 6);

        // halts: misaligned jr, then out-of-range jr
        for (int k = 0; k < 2; k++) begin
            do_reset(); idle(); idle();
            held_pc = fif.pc_o;
            step(0, 0, 0, 0, 0, 0, 1, (k == 0) ? 32'h402 : 32'h400);
            chk("halt_flag", fif.halted_o, 1'b1);
            chk("halt_valid", fif.instr_valid_o, 1'b0);
            chk("halt_pc", fif.pc_o, held_pc);
            idle();
            chk("halt_sticky", fif.halted_o, 1'b1);
            do_reset();
            chk("halt_rst_pc", fif.pc_o, RESET_PC);
            chk("halt_rst_flag", fif.halted_o, 1'b0);
        end

        // reset during stall with redirect pending
        idle(); idle();
        step(1, 1, 1, 32'd3, 1, 26'h5, 0, 0);
        chk("rst_stall_pc", fif.pc_o, RESET_PC);
        chk("rst_stall_valid", fif.instr_valid_o, 1'b0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit          r, st, br, j, jr;
            logic [31:0] off, ja;
            logic [25:0] jt;
            r   = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
            st  = ($urandom_range(0, 4) == 0);
            br  = ($urandom_range(0, 9) == 0);
            j   = ($urandom_range(0, 14) == 0);
            jr  = ($urandom_range(0, 19) == 0);
            off = $urandom_range(0, 40) - 20;
            jt  = 26'($urandom_range(0, 270));
            case ($urandom_range(0, 5))
                0:       ja = $urandom;
                1:       ja = ($urandom_range(0, 255) * 4) + 2;
                default: ja = $urandom_range(0, 255) * 4;
            endcase
            step(r, st, br, off, j, jt, jr, ja);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter and fetch stage that sits directly upstream of the instruction memory. It drives the word-aligned byte address into the memory and registers the returned word into an instruction register (IR) with a valid flag for the decode/execute logic. It resolves redirects (branch, jump, jump-register) coming back from decode, and handles stall, flush bubbles and an out-of-range HALT condition.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
IMEM_DEPTH, 8, log2 of instruction-memory word count; legal PC range is 0 .. 4*(2**IMEM_DEPTH)-4.

Ports:
clk  in  1  rising-edge clock; the only clock.
reset  in  1  synchronous, active-high reset.
pc_o  out  32  current PC; drives instruction-memory address A.
instr_i  in  32  instruction word read from memory at pc_o (combinational, same cycle).
stall_i  in  1  hold PC and IR this cycle.
branch_taken_i  in  1  conditional branch in IR resolved taken.
branch_offset_i  in  32  sign-extended 16-bit immediate of the branch in IR.
jump_i  in  1  J-type jump in IR.
jump_target_i  in  26  instr[25:0] of the jump.
jr_i  in  1  jump-register in IR.
jr_addr_i  in  32  register value for jr.
instr_o  out  32  IR contents.
ir_pc_o  out  32  PC of the instruction in IR.
instr_valid_o  out  1  IR holds a real instruction (0 = bubble).
halted_o  out  1  fetch stopped on an error.

Behaviour:
- Reset (reset=1 at posedge): PC<=RESET_PC, IR<=32'h0, ir_pc<=RESET_PC, instr_valid_o<=0, halted_o<=0, state<=FILL. Reset overrides every other input, including mid-stall and HALT.
- FSM states: FILL, RUN, HALT.
  - FILL: first cycle after reset. Capture IR<=instr_i, ir_pc<=PC, valid<=1, PC<=PC+4, go to RUN. stall_i and redirects are ignored in FILL.
  - RUN: normal operation (see priority below).
  - HALT: PC, IR and ir_pc frozen; valid=0; halted_o=1. Left only via reset.
- Redirects are qualified by instr_valid_o=1; when valid=0 they are ignored.
- RUN priority at each posedge, highest first:
  1. stall_i=1: hold PC, IR, ir_pc and valid. Redirects are ignored; decode must hold them until stall drops.
  2. jr_i: target = jr_addr_i.
  3. jump_i: target = {ir_pc+4 [31:28], jump_target_i, 2'b00}.
  4. branch_taken_i: target = ir_pc + 4 + (branch_offset_i << 2), modulo 2**32.
  5. No redirect: IR<=instr_i, ir_pc<=PC, valid<=1, PC<=PC+4.
- On any redirect (2–4): PC<=target, valid<=0. The word fetched this cycle is dropped, giving exactly one bubble cycle. The next cycle fetches from target.
- Error check, evaluated in RUN on the next-PC value:
  - If target[1:0]≠0, or next PC ≥ 4*(2**IMEM_DEPTH), go to HALT.
  - PC is not updated; halted_o=1 from the next cycle.
- Throughput: one instruction per cycle absent stall and redirect. Fetch latency is 1 cycle, pc_o to instr_o.
- pc_o is a direct register output; it never glitches between edges.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds outputs fetch_cnt_o[31:0] and redirect_cnt_o[31:0], both cleared by reset.
  - fetch_cnt_o increments on every posedge where IR loads a valid instruction.
  - redirect_cnt_o increments on every accepted redirect.
  - Both counters wrap at 2**32 and freeze in HALT.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then run 3 cycles, no redirects -> pc_o 0,4,8,12. instr_valid_o 0,1,1,1. ir_pc_o 0,0,4,8.
- IR at ir_pc=12 with branch_taken_i=1, offset=7 -> next pc_o=0x2C, one bubble (valid=0), then IR=mem[11] with ir_pc=0x2C.
- IR at ir_pc=0x18 with jump_i=1, target=26'h3 -> pc_o=0x0C next cycle, one bubble. Run the sum-under-6 loop program -> store executes after exactly 6 taken loop jumps.
- stall_i high 3 cycles mid-stream, with branch_taken_i asserted during the stall -> PC and IR constant, branch ignored. After stall, sequential fetch resumes.
- jr_i with jr_addr_i=0x402 (misaligned), and separately 0x400 with IMEM_DEPTH=8 -> HALT, halted_o=1, valid=0, pc_o unchanged. Then reset=1 -> pc_o=RESET_PC, halted_o=0.
- reset asserted during stall and while a redirect is pending -> next cycle state FILL, pc_o=RESET_PC, valid=0. With FETCH_PERF_CNT_EN, both counters read 0.
